// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter; master is the arbiter side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    import fifo_arb_pkg::*;

    localparam int unsigned OWNER_W = $clog2(N_REQ);

    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            gnt;
    logic                        fifo_wr_en;
    logic [DATA_WIDTH-1:0]       fifo_din;
    logic                        fifo_full;
    logic                        fifo_almost_full;
    logic [OWNER_W-1:0]          owner;
    logic                        busy;
    logic [STALL_CNT_W-1:0]      stall_cnt;

    modport master (
        input  req, req_data, fifo_full, fifo_almost_full,
        output gnt, fifo_wr_en, fifo_din, owner, busy, stall_cnt
    );

    modport slave (
        output req, req_data, fifo_full, fifo_almost_full,
        input  gnt, fifo_wr_en, fifo_din, owner, busy, stall_cnt
    );

endinterface

// File: rtl/rr_pick.sv
// Cyclic first-one search: lowest set bit of req at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] cand;

    // N is a power of two, so the W-bit add wraps exactly at N.
    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = ptr + W'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port from N_REQ producers.
// FIFO_ARB_AF_THROTTLE_EN: also hold off writes while fifo_almost_full is high.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.master bus
);

    localparam int unsigned OWNER_W = $clog2(N_REQ);
    localparam int unsigned BEAT_W  = $clog2(MAX_BURST) + 1;

    state_t                 state_q, state_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [OWNER_W-1:0]     pick_idx;
    logic                   pick_found;
    logic                   write_ok;
    logic                   owner_req;
    logic                   beat_go;
    logic                   last_beat;

`ifdef FIFO_ARB_AF_THROTTLE_EN
    assign write_ok = !bus.fifo_full && !bus.fifo_almost_full;
`else
    assign write_ok = !bus.fifo_full;
`endif

    assign owner_req = bus.req[owner_q];
    assign beat_go   = (state_q == BURST) && owner_req && write_ok;
    assign last_beat = (beat_cnt_q == BEAT_W'(MAX_BURST - 1));

    rr_pick #(
        .N (N_REQ)
    ) u_rr_pick (
        .req   (bus.req),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = BURST;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                // A dropped request or a full burst both hand the pointer on.
                if (!owner_req) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_q + OWNER_W'(1);
                end else if (write_ok) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (last_beat) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_q + OWNER_W'(1);
                    end
                end else if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt = '0;
        if (beat_go) begin
            bus.gnt[owner_q] = 1'b1;
        end
        bus.fifo_wr_en = beat_go;
        bus.fifo_din   = bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
        bus.owner      = owner_q;
        bus.busy       = (state_q == BURST);
        bus.stall_cnt  = stall_cnt_q;
    end

endmodule
